// File: rtl/register_file_pkg.sv
// register_file_pkg: shared encodings for the register file bank.
//   write_op encodings : OP_LOAD, OP_INC, OP_DEC, OP_CLEAR (2 bits)
//   read_write encodings: RW_READ (1), RW_WRITE (0)
package register_file_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/register_write_alu.sv
// register_write_alu: combinational in-place write operation unit.
// Computes the value written back into the selected register plus the
// carry/borrow and zero indications for the flags.
// Ports:
//   cur_val     in  DATA_WIDTH  current contents of the destination register
//   data_bus_in in  DATA_WIDTH  load data
//   write_op    in  2           operation (LOAD/INC/DEC/CLEAR)
//   result      out DATA_WIDTH  value to store
//   carry       out 1           INC overflow or DEC borrow
//   zero        out 1           result is zero
module register_write_alu
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] cur_val,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  input  logic [1:0]            write_op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (write_op)
      OP_LOAD: result = data_bus_in;
      OP_INC: begin
        result = cur_val + 1'b1;
        carry  = (cur_val == '1);
      end
      OP_DEC: begin
        result = cur_val - 1'b1;
        carry  = (cur_val == '0);
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/register_file_bank.sv
// register_file_bank: multi-entry register file for the datapath.
// One write port with in-place LOAD/INC/DEC/CLEAR, two registered read
// ports (1-cycle latency, read_valid pulse), zero and carry flags.
// Optional build macro REGISTER_FILE_ZERO_REG_EN: register 0 reads as zero
// and writes to it are dropped without touching the flags.
// Ports:
//   clk, reset_n (async active-low)
//   register_enable, read_write (1=read, 0=write), write_op
//   write_select, read_select_a, read_select_b, data_bus_in
//   data_bus_out_a, data_bus_out_b, read_valid, zero_flag, carry_flag
module register_file_bank
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  register_enable,
  input  logic                  read_write,
  input  logic [1:0]            write_op,
  input  logic [SEL_WIDTH-1:0]  write_select,
  input  logic [SEL_WIDTH-1:0]  read_select_a,
  input  logic [SEL_WIDTH-1:0]  read_select_b,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] data_bus_out_a,
  output logic [DATA_WIDTH-1:0] data_bus_out_b,
  output logic                  read_valid,
  output logic                  zero_flag,
  output logic                  carry_flag
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
  logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
  logic                  rvld_q, rvld_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;

  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  wr_allowed;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry, alu_zero;

`ifdef REGISTER_FILE_ZERO_REG_EN
  assign rd_a       = (read_select_a == '0) ? '0 : regs_q[read_select_a];
  assign rd_b       = (read_select_b == '0) ? '0 : regs_q[read_select_b];
  assign wr_allowed = (write_select != '0);
`else
  assign rd_a       = regs_q[read_select_a];
  assign rd_b       = regs_q[read_select_b];
  assign wr_allowed = 1'b1;
`endif

  register_write_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .cur_val     (regs_q[write_select]),
    .data_bus_in (data_bus_in),
    .write_op    (write_op),
    .result      (alu_result),
    .carry       (alu_carry),
    .zero        (alu_zero)
  );

  always_comb begin
    regs_d  = regs_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    rvld_d  = 1'b0;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (register_enable) begin
      if (read_write == RW_READ) begin
        out_a_d = rd_a;
        out_b_d = rd_b;
        rvld_d  = 1'b1;
      end else if (wr_allowed) begin
        regs_d[write_select] = alu_result;
        zero_d               = alu_zero;
        carry_d              = alu_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      rvld_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      rvld_q  <= rvld_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign data_bus_out_a = out_a_q;
  assign data_bus_out_b = out_b_q;
  assign read_valid     = rvld_q;
  assign zero_flag      = zero_q;
  assign carry_flag     = carry_q;

endmodule

// File: doc/register_file_bank.md
Name: register_file_bank

Overview:
Parametrised successor to the 8-bit four-entry register block: a multi-entry register file for the microprocessor datapath.
- One write port with in-place operations (load, increment, decrement, clear).
- Two registered read ports.
- Zero and carry flags.
- Sits between the data bus and the ALU/control unit; the control unit drives enable, read/write and selects.

Parameters:
- DATA_WIDTH, 8, bits per register and data bus width.
- NUM_REGS, 4, number of registers; must be a power of two, at least 2.
- SEL_WIDTH, $clog2(NUM_REGS), register select width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- register_enable  input  1  1 = perform the operation selected by read_write this cycle; 0 = idle.
- read_write  input  1  1 = read, 0 = write.
- write_op  input  2  write operation: 00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- write_select  input  SEL_WIDTH  destination register for writes.
- read_select_a  input  SEL_WIDTH  source register for port A.
- read_select_b  input  SEL_WIDTH  source register for port B.
- data_bus_in  input  DATA_WIDTH  write data for LOAD.
- data_bus_out_a  output  DATA_WIDTH  registered read data, port A.
- data_bus_out_b  output  DATA_WIDTH  registered read data, port B.
- read_valid  output  1  one-cycle pulse: read data updated this cycle.
- zero_flag  output  1  last write result was zero.
- carry_flag  output  1  last INC overflowed or last DEC borrowed.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers, data_bus_out_a/b, read_valid, zero_flag and carry_flag go to 0 immediately.
  - They stay 0 while reset_n is low.
  - Any operation in flight is discarded.
  - First operation is accepted on the first rising edge after reset_n rises.
- Idle (register_enable=0):
  - No state change.
  - Outputs hold their last values; read_valid=0.
- Read (register_enable=1, read_write=1):
  - At the edge, data_bus_out_a <= reg[read_select_a] and data_bus_out_b <= reg[read_select_b].
  - read_valid=1 for exactly that following cycle.
  - Latency is 1 cycle. Back-to-back reads are allowed every cycle; read_valid stays high.
  - Equal selects on A and B are legal; both ports return the same value.
  - Read data holds until the next read.
- Write (register_enable=1, read_write=0):
  - At the edge, reg[write_select] <= result.
  - LOAD: result = data_bus_in; carry_flag <= 0.
  - INC: result = reg+1, modulo 2^DATA_WIDTH; carry_flag <= 1 only when reg was all ones (wraps to 0).
  - DEC: result = reg-1, modulo 2^DATA_WIDTH; carry_flag <= 1 only when reg was 0 (wraps to all ones).
  - CLEAR: result = 0; carry_flag <= 0.
  - zero_flag <= (result == 0) for every write.
  - Flags change only on writes; reads leave them unchanged.
  - read_valid=0 after a write. data_bus_out_a/b are not updated by writes.
- Read-after-write to the same register on the next cycle returns the new value; no bypass path is needed.
- Selects are always in range by construction (power-of-two depth).

Optional Feature:
- Macro: REGISTER_FILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero: reads of index 0 return 0.
  - Writes to index 0 are discarded, and zero_flag and carry_flag are left unchanged.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package register_file_pkg:
  - write_op encodings OP_LOAD, OP_INC, OP_DEC, OP_CLEAR (2-bit localparams).
  - Read/write encodings RW_READ=1 and RW_WRITE=0.
- Sub-module register_write_alu: combinational.
  - Inputs: current value, data_bus_in, write_op.
  - Outputs: result, carry, zero.
  - Parametrised by DATA_WIDTH.
- Top holds the storage array, output registers and flags.

Test Plan:
- Reset: reset_n=0 mid-run after loading values -> all outputs 0 immediately (before the next edge); subsequent read of every register returns 0.
- Load/read: LOAD 8'h0F into r1 and 8'hA5 into r2, then read A=r1, B=r2 -> one cycle later out_a=8'h0F, out_b=8'hA5, read_valid=1 for one cycle; zero_flag=0, carry_flag=0.
- Wrap:
  - LOAD 8'hFF into r3, INC r3 -> r3=8'h00, zero_flag=1, carry_flag=1.
  - DEC r3 -> r3=8'hFF, zero_flag=0, carry_flag=1.
- Flag persistence: after the wrap, three reads -> flags unchanged. CLEAR r1 -> r1=0, zero_flag=1, carry_flag=0.
- Timing: read r2 immediately after a LOAD 8'h3C to r2 -> returns 8'h3C. Idle cycles between operations -> out_a/out_b hold, read_valid=0.
- Optional feature: with REGISTER_FILE_ZERO_REG_EN, LOAD 8'h55 to r0 -> read r0 returns 0 and flags are unchanged. Without the macro -> read r0 returns 8'h55.
